// File: rtl/pwm_motor_driver.sv
// pwm_motor_driver
//   Multi-channel H-bridge PWM driver. A shared counter runs 0..PERIOD-1.
//   Each channel turns a signed PID command into a duty threshold and a
//   direction, and holds it as "pending" until the next wrap. At the wrap it
//   becomes "active", and the per-channel FSM (COAST/FWD/REV/DEAD) advances.
//   Whole PWM periods of coast are inserted on every direction reversal.
//
// Ports
//   clk, rstn         system clock (rising edge), async active-low reset
//   u_valid_i         one-cycle command strobe
//   u_chn_i           target channel; values >= NUM_CHN are dropped
//   u_data_i          signed command
//   enable            0 forces coast on every channel
//   brake[i]          1 forces in1 = in2 = 1 on channel i (below enable)
//   motor_in1/in2     registered bridge inputs, one cycle behind the counter
//   period_start      high on each cycle where the counter is 0
//   fsm_state         debug: channel i state in [2*i+1:2*i]
//                     (0 COAST, 1 FWD, 2 REV, 3 DEAD)
//
// Handshake: a command is taken on any rising edge where u_valid_i is high.
// There is no ready signal; the block always accepts.
module pwm_motor_driver #(
  parameter int NUM_CHN      = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int CHN_WIDTH    = 3,
  parameter int CLK_FREQ     = 27_000_000,
  parameter int PWM_FREQ     = 100_000,
  parameter int U_MAX        = 1500,
  parameter int DUTY_MIN_PCT = 20,
  parameter int DUTY_MAX_PCT = 80,
  parameter int DEAD_PERIODS = 2,
  parameter int SLOW_DECAY   = 0
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         u_valid_i,
  input  logic [CHN_WIDTH-1:0]         u_chn_i,
  input  logic signed [DATA_WIDTH-1:0] u_data_i,
  input  logic                         enable,
  input  logic [NUM_CHN-1:0]           brake,
  output logic [NUM_CHN-1:0]           motor_in1,
  output logic [NUM_CHN-1:0]           motor_in2,
  output logic                         period_start,
  output logic [2*NUM_CHN-1:0]         fsm_state
);

  localparam int PERIOD = CLK_FREQ / PWM_FREQ;
  localparam int DMIN   = PERIOD * DUTY_MIN_PCT / 100;
  localparam int DMAX   = PERIOD * DUTY_MAX_PCT / 100;
  localparam int CW     = $clog2(PERIOD + 1);
  localparam int MW     = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    COAST = 2'd0,
    FWD   = 2'd1,
    REV   = 2'd2,
    DEAD  = 2'd3
  } state_t;

  // ---------------------------------------------------------------- counter
  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CW'(PERIOD - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      cnt          <= wrap ? '0 : cnt + 1'b1;
      period_start <= wrap;
    end
  end

  // ------------------------------------------------------ command -> thr
  logic signed [MW-1:0] u_ext;
  logic [MW-1:0]        u_mag;
  logic [MW-1:0]        u_sat;
  logic [MW-1:0]        thr_full;
  logic [CW-1:0]        thr_new;

  // Double width so the magnitude of the most negative value is representable.
  always_comb begin
    u_ext    = {{DATA_WIDTH{u_data_i[DATA_WIDTH-1]}}, u_data_i};
    u_mag    = u_ext[MW-1] ? $unsigned(-u_ext) : $unsigned(u_ext);
    u_sat    = (u_mag > MW'(U_MAX)) ? MW'(U_MAX) : u_mag;
    thr_full = MW'(DMIN) + (u_sat * MW'(DMAX - DMIN)) / MW'(U_MAX);
    thr_new  = (u_mag == '0) ? '0 : thr_full[CW-1:0];
  end

  // ---------------------------------------------------- pending registers
  logic [CW-1:0]      pend_thr [NUM_CHN];
  logic [NUM_CHN-1:0] pend_pos;
  logic [NUM_CHN-1:0] pend_neg;

  // Commands keep landing here even while disabled; loop match drops
  // out-of-range channel indices without indexing past the array.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CHN; i++) pend_thr[i] <= '0;
      pend_pos <= '0;
      pend_neg <= '0;
    end else begin
      for (int i = 0; i < NUM_CHN; i++) begin
        if (u_valid_i && (u_chn_i == CHN_WIDTH'(i))) begin
          pend_thr[i] <= thr_new;
          pend_pos[i] <= (u_mag != '0) && !u_ext[MW-1];
          pend_neg[i] <= u_ext[MW-1];
        end
      end
    end
  end

  // ------------------------------------------------ per-channel FSM + out
  logic [CW-1:0]      act_thr  [NUM_CHN];
  logic [3:0]         dead_cnt [NUM_CHN];
  state_t             st       [NUM_CHN];
  logic [NUM_CHN-1:0] below;

  always_comb begin
    below     = '0;
    fsm_state = '0;
    for (int i = 0; i < NUM_CHN; i++) begin
      below[i]          = (cnt < act_thr[i]);
      fsm_state[2*i+:2] = st[i];
    end
  end

  function automatic state_t sign_state(input logic pos, input logic neg);
    if (pos)      return FWD;
    else if (neg) return REV;
    else          return COAST;
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CHN; i++) begin
        act_thr[i]  <= '0;
        dead_cnt[i] <= '0;
        st[i]       <= COAST;
      end
      motor_in1 <= '0;
      motor_in2 <= '0;
    end else begin
      for (int i = 0; i < NUM_CHN; i++) begin
        // Outputs use the current state and compare, hence one cycle of lag.
        if (!enable) begin
          motor_in1[i] <= 1'b0;
          motor_in2[i] <= 1'b0;
        end else if (brake[i]) begin
          motor_in1[i] <= 1'b1;
          motor_in2[i] <= 1'b1;
        end else begin
          case (st[i])
            FWD: begin
              motor_in1[i] <= (SLOW_DECAY != 0) ? 1'b1 : below[i];
              motor_in2[i] <= (SLOW_DECAY != 0) ? !below[i] : 1'b0;
            end
            REV: begin
              motor_in1[i] <= (SLOW_DECAY != 0) ? !below[i] : 1'b0;
              motor_in2[i] <= (SLOW_DECAY != 0) ? 1'b1 : below[i];
            end
            default: begin
              motor_in1[i] <= 1'b0;
              motor_in2[i] <= 1'b0;
            end
          endcase
        end

        if (wrap) act_thr[i] <= pend_thr[i];

        if (!enable) begin
          st[i]       <= COAST;
          dead_cnt[i] <= '0;
        end else if (wrap) begin
          case (st[i])
            COAST: st[i] <= sign_state(pend_pos[i], pend_neg[i]);
            FWD: begin
              if (pend_neg[i]) begin
                if (DEAD_PERIODS == 0) begin
                  st[i] <= REV;
                end else begin
                  st[i]       <= DEAD;
                  dead_cnt[i] <= 4'(DEAD_PERIODS);
                end
              end else if (!pend_pos[i]) begin
                st[i] <= COAST;
              end
            end
            REV: begin
              if (pend_pos[i]) begin
                if (DEAD_PERIODS == 0) begin
                  st[i] <= FWD;
                end else begin
                  st[i]       <= DEAD;
                  dead_cnt[i] <= 4'(DEAD_PERIODS);
                end
              end else if (!pend_neg[i]) begin
                st[i] <= COAST;
              end
            end
            default: begin
              // dead_cnt counts periods still owed; 1 at a wrap means the
              // last one just ended. Sign changes here never reload it.
              if (dead_cnt[i] <= 4'd1) begin
                st[i]       <= sign_state(pend_pos[i], pend_neg[i]);
                dead_cnt[i] <= '0;
              end else begin
                dead_cnt[i] <= dead_cnt[i] - 4'd1;
              end
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_motor_driver.sv
// Bench for pwm_motor_driver: two instances (fast and slow decay) share
// all inputs. Expected per-period high counts are queued when a command
// is driven, then popped when a full period of output has been counted.
module tb_pwm_motor_driver;

  localparam int NUM_CHN = 4;
  localparam int PERIOD  = 270;

  logic               clk = 1'b0;
  logic               rstn;
  logic               u_valid;
  logic [2:0]         u_chn;
  logic signed [15:0] u_data;
  logic               enable;
  logic [NUM_CHN-1:0] brake;

  logic [NUM_CHN-1:0]   in1_a, in2_a, in1_b, in2_b;
  logic                 ps_a, ps_b;
  logic [2*NUM_CHN-1:0] st_a, st_b;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  // ------------------------------------------------------ clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  pwm_motor_driver dut_a (
    .clk(clk), .rstn(rstn), .u_valid_i(u_valid), .u_chn_i(u_chn),
    .u_data_i(u_data), .enable(enable), .brake(brake),
    .motor_in1(in1_a), .motor_in2(in2_a), .period_start(ps_a),
    .fsm_state(st_a)
  );

  pwm_motor_driver #(.SLOW_DECAY(1)) dut_b (
    .clk(clk), .rstn(rstn), .u_valid_i(u_valid), .u_chn_i(u_chn),
    .u_data_i(u_data), .enable(enable), .brake(brake),
    .motor_in1(in1_b), .motor_in2(in2_b), .period_start(ps_b),
    .fsm_state(st_b)
  );

  // ------------------------------------------------------------ checker
  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ------------------------------------------------------------ drivers
  // All drivers are entered and left on a falling edge.
  task automatic send_cmd(input logic [2:0] ch, input logic signed [15:0] d);
    u_valid = 1'b1;
    u_chn   = ch;
    u_data  = d;
    @(negedge clk);
    u_valid = 1'b0;
  endtask

  task automatic wait_wrap();
    int n = 0;
    while (ps_a !== 1'b1 && n < 2 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    if (ps_a !== 1'b1) check_eq("wrap_timeout", 0, 1);
  endtask

  task automatic expect_counts(input int e1, input int e2);
    exp_q.push_back(16'(e1));
    exp_q.push_back(16'(e2));
  endtask

  // Starts at the cnt==0 sample; counts the PERIOD output samples that
  // belong to this period (outputs lag the counter by one cycle).
  task automatic measure(input int ch, input bit slow, input string tag);
    int c1 = 0;
    int c2 = 0;
    logic [15:0] e;
    repeat (PERIOD) begin
      @(posedge clk);
      @(negedge clk);
      c1 += int'(slow ? in1_b[ch] : in1_a[ch]);
      c2 += int'(slow ? in2_b[ch] : in2_a[ch]);
    end
    if (exp_q.size() < 2) begin
      check_eq({tag, "_queue_empty"}, 32'(exp_q.size()), 2);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "_in1"}, 32'(c1), 32'(e));
      e = exp_q.pop_front();
      check_eq({tag, "_in2"}, 32'(c2), 32'(e));
    end
  endtask

  // ----------------------------------------------------------- sequence
  initial begin
    int n;
    rstn    = 1'b1;
    u_valid = 1'b0;
    u_chn   = '0;
    u_data  = '0;
    enable  = 1'b1;
    brake   = '0;
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_in1", 32'(in1_a), 0);
    check_eq("rst_in2", 32'(in2_a), 0);
    check_eq("rst_ps", 32'(ps_a), 0);
    check_eq("rst_fsm", 32'(st_a), 0);
    rstn = 1'b1;

    // Full forward on ch0; slow-decay ch3 at half scale
    wait_wrap();
    send_cmd(3'd0, 16'sd1500);
    send_cmd(3'd3, 16'sd750);
    wait_wrap();
    expect_counts(216, 0);
    measure(0, 1'b0, "ch0_full");
    expect_counts(270, 135);
    measure(3, 1'b1, "slow_ch3");

    // ch1 forward, reversed mid-period, two dead periods, then reverse
    send_cmd(3'd1, 16'sd750);
    wait_wrap();
    expect_counts(135, 0);
    fork
      measure(1, 1'b0, "ch1_fwd");
      begin
        repeat (135) @(negedge clk);
        send_cmd(3'd1, -16'sd750);
      end
    join
    check_eq("ch1_dead_state", 32'(st_a[3:2]), 3);
    expect_counts(0, 0);
    measure(1, 1'b0, "ch1_dead1");
    expect_counts(0, 0);
    measure(1, 1'b0, "ch1_dead2");
    expect_counts(0, 135);
    measure(1, 1'b0, "ch1_rev");

    // Magnitude extremes
    send_cmd(3'd2, -16'sd32768);
    send_cmd(3'd3, 16'sd4000);
    wait_wrap();
    expect_counts(0, 216);
    measure(2, 1'b0, "ch2_neg_max");
    expect_counts(216, 0);
    measure(3, 1'b0, "ch3_sat");

    // Zero command and an out-of-range channel
    send_cmd(3'd0, 16'sd0);
    send_cmd(3'd5, 16'sd1500);
    wait_wrap();
    check_eq("fsm_after_ignore", 32'(st_a), 32'h68);
    expect_counts(0, 0);
    measure(0, 1'b0, "ch0_zero");
    expect_counts(0, 135);
    measure(1, 1'b0, "ch1_ignore");

    // Brake on ch2
    brake = 4'b0100;
    @(negedge clk);
    check_eq("brake_in1", 32'(in1_a[2]), 1);
    check_eq("brake_in2", 32'(in2_a[2]), 1);
    brake = '0;
    @(negedge clk);

    // Disable mid-period; command accepted while disabled
    repeat (40) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check_eq("dis_in1", 32'(in1_a), 0);
    check_eq("dis_in2", 32'(in2_a), 0);
    send_cmd(3'd0, 16'sd750);
    wait_wrap();
    check_eq("dis_fsm_coast", 32'(st_a), 0);
    enable = 1'b1;
    @(negedge clk);
    wait_wrap();
    expect_counts(135, 0);
    measure(0, 1'b0, "ch0_after_enable");

    // Reset during a dead period on ch1
    send_cmd(3'd1, 16'sd750);
    wait_wrap();
    check_eq("ch1_dead_again", 32'(st_a[3:2]), 3);
    repeat (20) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check_eq("rst_async_in1", 32'(in1_a), 0);
    check_eq("rst_async_in2", 32'(in2_a), 0);
    check_eq("rst_async_fsm", 32'(st_a), 0);
    @(negedge clk);
    n = 0;
    rstn = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (ps_a !== 1'b1 && n < 1000);
    check_eq("restart_len", 32'(n), PERIOD);
    check_eq("rst_fsm_coast", 32'(st_a), 0);
    expect_counts(0, 0);
    measure(1, 1'b0, "ch1_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
